jk_ff_out_monitor: RTL and testbench
====================================

Name: jk_ff_out_monitor

Overview:
- Downstream consumer of the JK flip-flop stage; samples the flop's complementary outputs (q_o/qb_o) every clock.
- Produces registered rise/fall event pulses, a saturating toggle count and the length of the last completed high phase.
- Flags any cycle where the two outputs are not complementary.
- Used as the self-check/observation stage behind the JK flop in the sequential-logic lab chain.

Parameters:
- CNT_W, 8, width of toggle counter.
- LEN_W, 8, width of high-phase length counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge; 0 = reset.
- q_i  input  1  flop true output (driven from JK flop q_o).
- qb_i  input  1  flop complement output (driven from JK flop qb_o).
- clr_i  input  1  synchronous clear of counters and flags, active-high.
- rise_o  output  1  one-cycle pulse: q went 0->1.
- fall_o  output  1  one-cycle pulse: q went 1->0.
- toggle_cnt_o  output  CNT_W  count of rise+fall events, saturating.
- sat_o  output  1  sticky: toggle_cnt_o reached all-ones.
- high_len_o  output  LEN_W  sampled-cycle length of last completed high phase.
- len_valid_o  output  1  one-cycle pulse when high_len_o updates.
- comp_err_o  output  1  sticky: q_i == qb_i was sampled.

Behaviour:
- Reset (reset=0 at clk edge): all outputs 0, internal run counter 0, FSM = UNARMED.
- Priority: reset > clr_i > normal events.
- FSM states and transitions:
  - UNARMED: first sample goes to HIGH if q_i=1 (run=1), else LOW. No edge is reported on this priming sample.
  - LOW: on q_i=1, go to HIGH, rise_o=1 next cycle, run=1. On q_i=0, stay.
  - HIGH: on q_i=1, run=run+1, saturating at 2^LEN_W-1. On q_i=0, go to LOW, fall_o=1 next cycle, high_len_o<=run, len_valid_o=1 next cycle.
- Latency: every output reflects the input sampled at the previous clk edge, i.e. one cycle of latency. All outputs are registered.
- rise_o, fall_o and len_valid_o are high for exactly one cycle per event.
- Every rise or fall increments toggle_cnt_o by 1. At 2^CNT_W-1 the counter holds and sat_o sets. sat_o stays set until clr_i or reset.
- comp_err_o:
  - Sets the cycle after any armed sample with q_i==qb_i. It is sticky.
  - The UNARMED priming sample is checked too.
  - Edge detection uses q_i only; qb_i never affects the FSM.
- clr_i=1:
  - Next cycle all outputs are 0 and the FSM returns to UNARMED (re-prime).
  - Any edge sampled in the same cycle is discarded.
- high_len_o holds its value between completed phases.
- A phase cut by reset or clr_i produces no fall_o or len_valid_o.
- Toggling every cycle (J=K=1 upstream) gives alternating rise/fall pulses with high_len_o=1. This is a valid case.

Test Plan:
- Hold reset=0 for 2 cycles with q_i=1, qb_i=0 -> all outputs 0. Release reset and hold q_i=1 -> no rise_o; toggle_cnt_o=0.
- After priming low: q_i=0 for 2 cycles, then 1 for 3 cycles, then 0 (qb_i complementary) -> rise_o one pulse, then fall_o plus len_valid_o one pulse each; high_len_o=3; toggle_cnt_o=2.
- q_i toggling every cycle for 300 edges, CNT_W=8 -> toggle_cnt_o stops at 255 and sat_o=1; every len_valid_o reports high_len_o=1.
- q_i high for 300 cycles, LEN_W=8, then low -> high_len_o=255.
- q_i=qb_i=1 for one cycle -> comp_err_o=1 next cycle and stays 1. Then clr_i=1 for one cycle -> comp_err_o=0, toggle_cnt_o=0, sat_o=0; the next sample only primes (no edge pulse).
- reset=0 mid-high-phase (run=4), then release with q_i=0 -> no fall_o, no len_valid_o; high_len_o=0.

Source files
------------

// File: rtl/jk_ff_out_monitor.sv
// Observation stage behind the JK flop: edge pulses, saturating toggle count,
// last completed high-phase length and a sticky complementarity error flag.
module jk_ff_out_monitor #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_i,
    input  logic             qb_i,
    input  logic             clr_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] toggle_cnt_o,
    output logic             sat_o,
    output logic [LEN_W-1:0] high_len_o,
    output logic             len_valid_o,
    output logic             comp_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        LOW     = 2'd1,
        HIGH    = 2'd2
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] run;

    logic             is_rise_c;
    logic             is_fall_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [LEN_W-1:0] run_inc_c;

    // Edge decode and saturating increments from the current armed state
    always_comb begin
        is_rise_c = (state == LOW)  &&  q_i;
        is_fall_c = (state == HIGH) && !q_i;
        cnt_inc_c = (toggle_cnt_o == CNT_MAX) ? toggle_cnt_o : toggle_cnt_o + CNT_W'(1);
        run_inc_c = (run == LEN_MAX) ? run : run + LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_i) begin
            state        <= UNARMED;
            run          <= '0;
            rise_o       <= 1'b0;
            fall_o       <= 1'b0;
            toggle_cnt_o <= '0;
            sat_o        <= 1'b0;
            high_len_o   <= '0;
            len_valid_o  <= 1'b0;
            comp_err_o   <= 1'b0;
        end else begin
            rise_o      <= is_rise_c;
            fall_o      <= is_fall_c;
            len_valid_o <= is_fall_c;

            if (q_i == qb_i) begin
                comp_err_o <= 1'b1;
            end

            if (is_rise_c || is_fall_c) begin
                toggle_cnt_o <= cnt_inc_c;
                if (cnt_inc_c == CNT_MAX) begin
                    sat_o <= 1'b1;
                end
            end

            case (state)
                UNARMED: begin
                    // Priming sample: establish level without reporting an edge
                    state <= q_i ? HIGH : LOW;
                    run   <= q_i ? LEN_W'(1) : '0;
                end
                LOW: begin
                    if (q_i) begin
                        state <= HIGH;
                        run   <= LEN_W'(1);
                    end
                end
                HIGH: begin
                    if (q_i) begin
                        run <= run_inc_c;
                    end else begin
                        state      <= LOW;
                        high_len_o <= run;
                    end
                end
                default: begin
                    state <= UNARMED;
                    run   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_ff_out_monitor.sv
// Bench for jk_ff_out_monitor: directed scenarios plus random traffic checked
// against a level/phase-based reference model.
module tb_jk_ff_out_monitor;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned CNT_TOP = (1 << CNT_W) - 1;
    localparam int unsigned LEN_TOP = (1 << LEN_W) - 1;

    logic             clk;
    logic             reset;
    logic             q_i;
    logic             qb_i;
    logic             clr_i;
    logic             rise_o;
    logic             fall_o;
    logic [CNT_W-1:0] toggle_cnt_o;
    logic             sat_o;
    logic [LEN_W-1:0] high_len_o;
    logic             len_valid_o;
    logic             comp_err_o;

    jk_ff_out_monitor #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .q_i          (q_i),
        .qb_i         (qb_i),
        .clr_i        (clr_i),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .toggle_cnt_o (toggle_cnt_o),
        .sat_o        (sat_o),
        .high_len_o   (high_len_o),
        .len_valid_o  (len_valid_o),
        .comp_err_o   (comp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total;
    int unsigned bad;

    // Reference model: tracks the last sampled level and the length of the
    // ongoing high phase as plain integers.
    bit          m_armed;
    bit          m_prev_q;
    int unsigned m_run;
    int unsigned m_cnt;
    int unsigned m_hlen;
    bit          m_rise, m_fall, m_lv, m_sat, m_cerr;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_armed = 0; m_prev_q = 0; m_run = 0; m_cnt = 0; m_hlen = 0;
        m_rise = 0; m_fall = 0; m_lv = 0; m_sat = 0; m_cerr = 0;
    endtask

    task automatic model_update(input bit r, input bit q, input bit qb, input bit clr);
        if (!r || clr) begin
            model_clear();
        end else begin
            m_rise = 0; m_fall = 0; m_lv = 0;
            if (q == qb) m_cerr = 1;
            if (!m_armed) begin
                m_armed = 1;
                m_run   = q ? 1 : 0;
            end else if (!m_prev_q && q) begin
                m_rise = 1;
                m_run  = 1;
                m_cnt++;
            end else if (m_prev_q && q) begin
                m_run++;
            end else if (m_prev_q && !q) begin
                m_fall = 1;
                m_lv   = 1;
                m_hlen = (m_run > LEN_TOP) ? LEN_TOP : m_run;
                m_cnt++;
            end
            m_prev_q = q;
            if (m_cnt > CNT_TOP) m_cnt = CNT_TOP;
            if (m_cnt == CNT_TOP) m_sat = 1;
        end
    endtask

    task automatic compare_all();
        check("rise",      32'(rise_o),       32'(m_rise));
        check("fall",      32'(fall_o),       32'(m_fall));
        check("len_valid", 32'(len_valid_o),  32'(m_lv));
        check("toggle_cnt",32'(toggle_cnt_o), m_cnt);
        check("sat",       32'(sat_o),        32'(m_sat));
        check("high_len",  32'(high_len_o),   m_hlen);
        check("comp_err",  32'(comp_err_o),   32'(m_cerr));
    endtask

    // One clock: drive on falling edge, model on rising edge, compare just after
    task automatic step(input bit r, input bit q, input bit qb, input bit clr);
        @(negedge clk);
        reset = r; q_i = q; qb_i = qb; clr_i = clr;
        @(posedge clk);
        model_update(r, q, qb, clr);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit q, input int unsigned n);
        for (int i = 0; i < int'(n); i++) step(1'b1, q, ~q, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        reset = 1'b0; q_i = 1'b1; qb_i = 1'b0; clr_i = 1'b0;

        // Reset held with q high, then release: priming only, no rise
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_cnt", 32'(toggle_cnt_o), 0);
        drive(1'b1, 3);
        check("prime_no_rise", 32'(rise_o), 0);
        check("prime_cnt", 32'(toggle_cnt_o), 0);

        // Primed low, 3-cycle high phase
        step(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 2);
        drive(1'b1, 3);
        drive(1'b0, 1);
        check("phase3_len", 32'(high_len_o), 3);
        check("phase3_lv", 32'(len_valid_o), 1);
        check("phase3_cnt", 32'(toggle_cnt_o), 2);
        drive(1'b0, 1);
        check("lv_one_cycle", 32'(len_valid_o), 0);
        check("len_hold", 32'(high_len_o), 3);

        // Toggle every cycle for 300 edges: counter saturates
        step(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1);
        for (int i = 0; i < 300; i++) begin
            drive(i[0] ? 1'b0 : 1'b1, 1);
            if (len_valid_o) check("toggle_len", 32'(high_len_o), 1);
        end
        check("sat_cnt", 32'(toggle_cnt_o), CNT_TOP);
        check("sat_flag", 32'(sat_o), 1);

        // Long high phase: length saturates
        step(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1);
        drive(1'b1, 300);
        drive(1'b0, 1);
        check("long_len", 32'(high_len_o), LEN_TOP);

        // Complementarity error, sticky, then cleared; next sample only primes
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("cerr_set", 32'(comp_err_o), 1);
        drive(1'b0, 2);
        check("cerr_sticky", 32'(comp_err_o), 1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_cerr", 32'(comp_err_o), 0);
        check("clr_cnt", 32'(toggle_cnt_o), 0);
        check("clr_sat", 32'(sat_o), 0);
        drive(1'b1, 1);
        check("reprime_rise", 32'(rise_o), 0);

        // Reset cuts a high phase: no fall/len reported afterwards
        step(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1);
        drive(1'b1, 4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1);
        check("cut_fall", 32'(fall_o), 0);
        check("cut_lv", 32'(len_valid_o), 0);
        check("cut_len", 32'(high_len_o), 0);
        drive(1'b0, 1);

        // Random traffic with occasional glitches, clears and resets
        begin
            bit q_r;
            q_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit qb_r, clr_r, rst_r;
                if ($urandom_range(0, 3) == 0) q_r = ~q_r;
                qb_r  = ($urandom_range(0, 49) == 0) ? q_r : ~q_r;
                clr_r = ($urandom_range(0, 149) == 0);
                rst_r = ($urandom_range(0, 299) != 0);
                step(rst_r, q_r, qb_r, clr_r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
